// File: rtl/event_op_queue.sv
// Event-driven operand unit: each in0 strobe computes op(in1, in2) and queues the
// result in a show-ahead FIFO with a valid/ready output. Define EVENT_OP_ADD_EN to make op=11 an adder.
module event_op_queue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in0,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         in1,
    input  logic [WIDTH-1:0]         in2,
    output logic [WIDTH-1:0]         out,
    output logic                     out_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          result;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            drop;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        result = '0;
        case (op)
            2'b00: result.data = in1 & in2;
            2'b01: result.data = in1 | in2;
            2'b10: result.data = in1 ^ in2;
            2'b11: begin
`ifdef EVENT_OP_ADD_EN
                {result.carry, result.data} = {1'b0, in1} + {1'b0, in2};
`else
                result.data = ~(in1 & in2);
`endif
            end
        endcase
    end

    // Occupancy flags come from the level register, never from pointer comparison.
    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign out_valid = !empty;

    assign head      = mem[rd_ptr];
    assign out       = empty ? '0 : head.data;
    assign out_carry = !empty && head.carry;

    // A pop frees a slot on the same edge, so a full queue still accepts a push.
    assign pop  = out_valid && out_ready;
    assign push = in0 && (!full || pop);
    assign drop = in0 && full && !pop;

    // NOTE: storage is deliberately not reset; stale entries are never visible because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= result;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: doc/event_op_queue.md
# event_op_queue

Parametrised successor to the single-event operand block. Each clock edge with the event strobe high computes a selectable bitwise or arithmetic operation on two WIDTH-bit operands. The result is queued in a DEPTH-entry FIFO and presented downstream through a valid/ready handshake. The block also tracks queue occupancy and counts events dropped because the queue was full.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥1)
- DEPTH, 4, queue entries; power of two, ≥2

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in0  input  1  event strobe; sampled every rising edge
- op  input  2  operation select, sampled with in0
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- out  output  WIDTH  result at queue head; 0 when empty
- out_carry  output  1  carry at queue head; 0 when empty
- out_valid  output  1  queue head holds a result
- out_ready  input  1  downstream accepts head this cycle
- full  output  1  level == DEPTH
- empty  output  1  level == 0
- level  output  $clog2(DEPTH)+1  entries currently held
- drop_cnt  output  8  events lost while full, saturating

## Operation
- Op encoding:
  - 00: out = in1 & in2, carry 0
  - 01: out = in1 | in2, carry 0
  - 10: out = in1 ^ in2, carry 0
  - 11: see Configuration
- Push: in0=1 and (!full or pop in same cycle). Stores {carry, result} computed from in1/in2/op at that edge.
- Pop: out_valid=1 and out_ready=1. Advances the read pointer.
- Show-ahead FIFO:
  - out/out_carry reflect the head entry combinationally from storage.
  - Both are forced to 0 when empty.
  - out_valid = !empty.
- Simultaneous push and pop:
  - Both happen; level unchanged.
  - Applies when full as well: the push is accepted and drop_cnt does not change.
  - Applies when empty: only the push takes effect, since out_valid=0 so no pop occurs.
- Drop: in0=1, full=1, no pop that cycle.
  - Event discarded; queue contents unchanged.
  - drop_cnt increments, saturating at 255.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are derived from level, not from pointer compare.
- FIFO order is strict; no reordering, no bypass.
- in0=0 edges have no effect on the queue. op, in1 and in2 are don't-care then.

## Timing
- Reset (rst=1 at rising edge) clears the following on that edge:
  - pointers and level = 0, empty=1, full=0
  - out_valid=0, out=0, out_carry=0
  - drop_cnt=0
  - Queue storage need not be cleared.
- Reset overrides any simultaneous push or pop. Entries in flight mid-operation are discarded.
- Latency: event at edge N into an empty queue gives out_valid=1 and out valid after edge N (readable in cycle N+1).
- Throughput: one push and one pop per cycle sustained.
- out_ready is don't-care while out_valid=0.
- level, full, empty and drop_cnt are registered and update on the same edge as the push/pop/drop.

## Configuration
- Macro: EVENT_OP_ADD_EN.
- Defined: op=11 gives {out_carry, out} = in1 + in2, a (WIDTH+1)-bit unsigned sum. Carry is the MSB.
- Undefined: op=11 gives out = ~(in1 & in2) (NAND), out_carry=0. The adder is not synthesised.
- All other ops and all queue behaviour are identical in both builds.

## Test plan
All scenarios use WIDTH=4, DEPTH=4.

- Single event: in1=4'b1001, in2=4'b1101, op=00, in0 pulsed for one edge, out_ready=0.
  - Next cycle: out=4'b1001, out_carry=0, out_valid=1, level=1.
  - Then out_ready=1 for one edge: empty=1, out=0.
- Op 11 with in1=4'b1001, in2=4'b1101:
  - With EVENT_OP_ADD_EN: out=4'b0110, out_carry=1.
  - Without it: out=4'b0110, out_carry=0.
  - Repeat with in1=4'b0011, in2=4'b0101: add gives out=4'b1000, carry 0; NAND gives out=4'b1110.
- Fill and drop: with out_ready=0, push events with in1=1,2,3,4 (op=01, in2=0).
  - After the 4th push: full=1, level=4.
  - 5th event: drop_cnt=1, level stays 4.
  - Draining then returns 1,2,3,4 in order; empty=1 after the 4th pop.
- Full with simultaneous push and pop: queue full, in0=1 (in1=4'hF) and out_ready=1 on the same edge.
  - Level stays 4; drop_cnt unchanged.
  - Draining ends with 4'hF.
- Reset mid-operation: level=3 and in0=1 asserted with rst=1 on the same edge.
  - Next cycle: empty=1, level=0, out_valid=0, out=0, drop_cnt=0.
- Counter saturation: queue held full, 300 consecutive dropped events.
  - drop_cnt reads 255 and stays at 255.
